// File: rtl/stream_mux_4to1.sv
// Four-to-one valid/ready stream multiplexer. Round-robin arbitration between packets;
// a packet holds its channel until its last beat. Each beat is tagged with its source index.
module stream_mux_4to1 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_last,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         lock_ch_q, lock_ch_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [1:0]         out_sel_q, out_sel_d;

  logic               load_en_s;
  logic [2:0]         pick_s;
  logic [3:0]         grant_s;
  logic [1:0]         gidx_s;
  logic               accept_s;

  // Returns {found, index}; the search starts after p, so p itself has lowest priority.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      c = p + 2'(k);
      if (v[c]) begin
        res = {1'b1, c};
      end
    end
    return res;
  endfunction

  // Arbitration: grant selection and per-channel ready.
  always_comb begin
    load_en_s = !out_valid_q || out_ready;
    pick_s    = rr_pick(in_valid, ptr_q);
    grant_s   = 4'b0000;
    gidx_s    = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (pick_s[2]) begin
          grant_s = 4'b0001 << pick_s[1:0];
          gidx_s  = pick_s[1:0];
        end else begin
          grant_s = 4'b0000;
        end
      end
      ST_LOCKED: begin
        if (in_valid[lock_ch_q]) begin
          grant_s = 4'b0001 << lock_ch_q;
          gidx_s  = lock_ch_q;
        end else begin
          grant_s = 4'b0000;
        end
      end
      default: begin
        grant_s = 4'b0000;
      end
    endcase
    if (load_en_s && !rst) begin
      in_ready = grant_s;
    end else begin
      in_ready = 4'b0000;
    end
    accept_s = |in_ready;
  end

  // Next-state: load an accepted beat, or drain the output register.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gidx_s)*WIDTH +: WIDTH];
      out_last_d  = in_last[gidx_s];
      out_sel_d   = gidx_s;
      ptr_d       = gidx_s;
      lock_ch_d   = gidx_s;
      if (in_last[gidx_s]) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_LOCKED;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd3;
      lock_ch_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_4to1.sv
// Bench for stream_mux_4to1: a per-cycle reference model plus directed scenarios
// with hand-computed expectations on the captured output beats.
module tb_stream_mux_4to1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_mux_4to1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: abstract packet/arbitration state held as plain integers.
  bit          started = 1'b0;
  int          m_ptr, m_lock;
  bit          m_locked, m_ov, m_ol;
  logic [7:0]  m_od;
  int          m_os;
  logic [10:0] cap[$];

  function automatic logic [3:0] exp_ready();
    if (rst) return 4'b0000;
    if (m_ov && !out_ready) return 4'b0000;
    if (m_locked) return in_valid[m_lock] ? 4'(1 << m_lock) : 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      int c = (m_ptr + k) % 4;
      if (in_valid[c]) return 4'(1 << c);
    end
    return 4'b0000;
  endfunction

  function automatic int idx_of(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started  <= 1'b1;
      m_ptr    <= 3;
      m_locked <= 1'b0;
      m_lock   <= 0;
      m_ov     <= 1'b0;
      m_od     <= 8'h00;
      m_ol     <= 1'b0;
      m_os     <= 0;
    end else if (exp_ready() != 4'b0000) begin
      m_ov     <= 1'b1;
      m_od     <= in_data[idx_of(exp_ready())*8 +: 8];
      m_ol     <= in_last[idx_of(exp_ready())];
      m_os     <= idx_of(exp_ready());
      m_ptr    <= idx_of(exp_ready());
      m_lock   <= idx_of(exp_ready());
      m_locked <= !in_last[idx_of(exp_ready())];
    end else if (out_ready) begin
      m_ov <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, exp_ready());
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("out_last", out_last, m_ol);
      chk("out_sel", out_sel, m_os);
      if (!rst && out_valid && out_ready) cap.push_back({out_last, out_sel, out_data});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
    in_valid = v;
    in_last  = l;
    in_data  = d;
  endtask

  logic [3:0] lv [12] = '{4'b1111, 4'b0000, 4'b1111, 4'b0101, 4'b1010, 4'b1111,
                          4'b0011, 4'b1100, 4'b1111, 4'b0000, 4'b1111, 4'b1111};

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(4'b0000, 4'b0000, 32'h0);
    repeat (2) cyc();

    // Round robin, all single-beat packets.
    rst = 1'b0;
    drive(4'b1111, 4'b1111, 32'h13121110);
    #1 chk("rr_first_ready", in_ready, 4'b0001);
    repeat (8) cyc();
    drive(4'b0000, 4'b0000, 32'h0);
    cyc();
    chk("rr_count", cap.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_sel", cap[i][9:8], 32'(i % 4));
      chk("rr_data", cap[i][7:0], 32'(8'h10 + i % 4));
    end

    // Locked 3-beat packet on channel 2 with channels 0 and 1 competing.
    cap.delete();
    drive(4'b0100, 4'b0000, 32'h00A00000);
    cyc();
    drive(4'b0111, 4'b0011, 32'h00A10201);
    #1 chk("lock_ready1", in_ready, 4'b0100);
    cyc();
    drive(4'b0111, 4'b0111, 32'h00A20201);
    #1 chk("lock_ready2", in_ready, 4'b0100);
    cyc();
    drive(4'b0011, 4'b0011, 32'h00000201);
    #1 chk("lock_after", in_ready, 4'b0001);
    cyc();
    drive(4'b0000, 4'b0000, 32'h0);
    cyc();
    chk("lock_count", cap.size(), 4);
    chk("lock_b0", cap[0], {1'b0, 2'd2, 8'hA0});
    chk("lock_b1", cap[1], {1'b0, 2'd2, 8'hA1});
    chk("lock_b2", cap[2], {1'b1, 2'd2, 8'hA2});
    chk("lock_next", cap[3], {1'b1, 2'd0, 8'h01});

    // Locked channel drops valid for two cycles while channel 1 waits.
    cap.delete();
    drive(4'b0100, 4'b0000, 32'h00A00000);
    cyc();
    drive(4'b0010, 4'b0010, 32'h00000200);
    #1 chk("gap_ready1", in_ready, 4'b0000);
    cyc();
    #1 chk("gap_ready2", in_ready, 4'b0000);
    cyc();
    chk("gap_count", cap.size(), 1);
    drive(4'b0110, 4'b0010, 32'h00A10200);
    #1 chk("gap_resume", in_ready, 4'b0100);
    cyc();
    drive(4'b0110, 4'b0110, 32'h00A20200);
    cyc();
    drive(4'b0010, 4'b0010, 32'h00000200);
    #1 chk("gap_after", in_ready, 4'b0010);
    cyc();
    drive(4'b0000, 4'b0000, 32'h0);
    cyc();
    chk("gap_total", cap.size(), 4);
    chk("gap_b1", cap[1], {1'b0, 2'd2, 8'hA1});
    chk("gap_b2", cap[2], {1'b1, 2'd2, 8'hA2});
    chk("gap_next", cap[3], {1'b1, 2'd1, 8'h02});

    // Backpressure holds the output register stable.
    cap.delete();
    out_ready = 1'b0;
    drive(4'b0010, 4'b0010, 32'h00005500);
    cyc();
    drive(4'b0011, 4'b0011, 32'h00005501);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 8'h55);
      chk("bp_sel", out_sel, 2'd1);
      chk("bp_ready", in_ready, 4'b0000);
      cyc();
    end
    drive(4'b0000, 4'b0000, 32'h0);
    out_ready = 1'b1;
    cyc();
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_count", cap.size(), 1);
    chk("bp_beat", cap[0], {1'b1, 2'd1, 8'h55});

    // Continuous traffic: a beat every cycle with mixed packet lengths.
    cap.delete();
    for (int i = 0; i < 12; i++) begin
      drive(4'b1111, lv[i], {4'h3, 4'(i), 4'h2, 4'(i), 4'h1, 4'(i), 4'h0, 4'(i)});
      cyc();
      chk("stream_valid", out_valid, 1'b1);
    end
    drive(4'b0000, 4'b0000, 32'h0);
    cyc();
    chk("stream_count", cap.size(), 12);

    // Reset while locked with a beat pending.
    out_ready = 1'b0;
    drive(4'b1000, 4'b0000, 32'h77000000);
    cyc();
    chk("rst_pend_valid", out_valid, 1'b1);
    chk("rst_pend_sel", out_sel, 2'd3);
    rst = 1'b1;
    #1 chk("rst_ready", in_ready, 4'b0000);
    cyc();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sel", out_sel, 2'd0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_last", out_last, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(4'b1111, 4'b1111, 32'h13121110);
    #1 chk("rst_first_ready", in_ready, 4'b0001);
    cyc();
    chk("rst_first_sel", out_sel, 2'd0);
    chk("rst_first_data", out_data, 8'h10);
    drive(4'b0000, 4'b0000, 32'h0);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_4to1.md
# stream_mux_4to1

Four-input, one-output streaming multiplexer with round-robin arbitration and packet locking. It merges four valid/ready channels onto one registered output channel, tagging each beat with its source index. It is the gathering end of the 1-to-4 demultiplexer fabric: it sits where the four fanned-out lanes reconverge onto a single shared consumer.

## Interface
- WIDTH, 8, data bits per beat
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  4  per-channel beat valid, bit i = channel i
- in_data  input  4*WIDTH  channel i data at [i*WIDTH +: WIDTH]
- in_last  input  4  per-channel end-of-packet flag, qualified by in_valid
- in_ready  output  4  per-channel accept, at most one bit high
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  beat data
- out_last  output  1  beat is end of packet
- out_sel  output  2  source channel index of the beat
- out_ready  input  1  consumer accepts beat

## Operation
- Transfer on any channel occurs on a cycle where valid & ready are both high at the clock edge.
- load_en = !out_valid | out_ready. The output register loads only when load_en is high.
- State machine, 2 states:
  - IDLE: no packet in progress. Grant goes to the first valid channel, searching ptr+1, ptr+2, ptr+3, ptr (mod 4). ptr is the last granted channel.
  - LOCKED: packet in progress on channel lock_ch. Grant is lock_ch only, and only if in_valid[lock_ch]. Other channels get no grant.
- in_ready[i] = load_en & grant[i]. grant is one-hot or zero. in_ready is combinational from in_valid, state, ptr and out_ready.
- On an accepted beat from channel g:
  - out_data, out_last and out_sel load from channel g; out_valid is set to 1.
  - ptr is set to g.
  - If in_last[g] = 0, the next state is LOCKED with lock_ch = g. If in_last[g] = 1, the next state is IDLE.
- If out_ready is high and no beat is accepted, out_valid clears to 0. out_data, out_sel and out_last hold their values.
- If out_valid is high and out_ready is low, all output fields hold stable and in_ready is all zero.
- Single-beat packets (in_last = 1 on the first beat) never enter LOCKED.
- A LOCKED channel whose in_valid drops keeps the lock. The mux idles until that channel resumes. There is no timeout.
- Sources must not make in_valid depend on in_ready, because in_ready depends combinationally on in_valid.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_last = 0, out_sel = 0, state = IDLE, ptr = 3. With ptr = 3, channel 0 has first priority after reset.
- in_ready may be asserted in the cycle of reset deassertion. While rst is high, in_ready is 0.
- Latency: a beat accepted at edge N is visible on the outputs from edge N until it is consumed.
- Throughput: 1 beat per cycle with out_ready held high, including back-to-back beats from different channels in IDLE.
- Simultaneous drain and load: out_valid stays 1 and the new beat replaces the old one at the same edge.
- Reset mid-packet returns to IDLE and ptr = 3. Any beat in the output register is discarded with out_valid = 0.
- ptr wraps from 3 to 0.

## Test plan
- Reset, then assert in_valid = 4'b1111 and all in_last = 1, with out_ready = 1 held. Required: out_sel sequence 0, 1, 2, 3, 0, … with one beat per cycle, and in_ready one-hot following the same order.
- Channel 2 sends a 3-beat packet with data 0xA0, 0xA1, 0xA2 and last on the third beat, while channels 0 and 1 stay valid. Required: output 0xA0, 0xA1, 0xA2 contiguous on out_sel = 2, and in_ready[0] and in_ready[1] stay 0 until the last beat. Channel 0 is granted next.
- Same 3-beat packet on channel 2, but in_valid[2] drops for 2 cycles after the first beat, with channel 1 valid. Required: no output beats during the gap, channel 1 is not granted, and the packet completes when channel 2 resumes.
- Channel 1 sends data 0x55 with out_ready = 0 for 4 cycles. Required: out_valid = 1, out_data = 0x55 and out_sel = 1 stay stable, and in_ready = 0 throughout. Release out_ready; the beat is consumed in 1 cycle.
- Continuous traffic with out_ready = 1. Required: one beat per cycle, and each accepted beat replaces the previous one at the same edge with no bubble.
- Assert rst in LOCKED state while a beat is pending. Required: the next cycle has out_valid = 0, out_sel = 0, out_data = 0 and state IDLE. Then with all channels valid, channel 0 is granted first.
